// File: rtl/queue_sensor_conditioner_pkg.sv
// Shared constants for the queue manager: sensor conditioning defaults and queue capacity.
package abqm_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_STUCK_CYCLES    = 1024;
  localparam int unsigned DEF_DB_W            = 3;
  localparam int unsigned DEF_ST_W            = 11;
  localparam int unsigned QUEUE_CAPACITY      = 7;

endpackage

// File: rtl/queue_sensor_conditioner_if.sv
// Raw sensor inputs and conditioned event/level outputs of the queue sensor front end.
interface queue_sensor_conditioner_if;

  logic in_raw;
  logic out_raw;
  logic in_pulse;
  logic out_pulse;
  logic in_level;
  logic out_level;
  logic sensor_stuck;

  modport master (
    output in_raw, out_raw,
    input  in_pulse, out_pulse, in_level, out_level, sensor_stuck
  );

  modport slave (
    input  in_raw, out_raw,
    output in_pulse, out_pulse, in_level, out_level, sensor_stuck
  );

endinterface

// File: rtl/queue_sensor_conditioner_sensor_debounce.sv
// One sensor channel: two-flop synchroniser, debounce to a stable level, and stuck-high timer.
module sensor_debounce
  import abqm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned STUCK_CYCLES    = DEF_STUCK_CYCLES,
  parameter int unsigned DB_W            = DEF_DB_W,
  parameter int unsigned ST_W            = DEF_ST_W
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_stuck_c
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_MAX  = ST_W'(STUCK_CYCLES);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic [DB_W-1:0] r_cnt;
  logic [ST_W-1:0] r_stcnt;

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_stcnt <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + DB_W'(1);
      end
      if (!r_level) begin
        r_stcnt <= '0;
      end else if (r_stcnt != ST_MAX) begin
        r_stcnt <= r_stcnt + ST_W'(1);
      end
    end
  end

  assign o_level   = r_level;
  assign o_stuck_c = (r_stcnt == ST_MAX);

endmodule

// File: rtl/queue_sensor_conditioner.sv
// Queue manager front end: conditions entry/exit sensors into exclusive one-cycle events.
module queue_sensor_conditioner
  import abqm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned STUCK_CYCLES    = DEF_STUCK_CYCLES,
  parameter int unsigned DB_W            = DEF_DB_W,
  parameter int unsigned ST_W            = DEF_ST_W
) (
  input logic                       clk,
  input logic                       reset,
  queue_sensor_conditioner_if.slave sns
);

  logic w_in_level;
  logic w_out_level;
  logic w_in_stuck;
  logic w_out_stuck;
  logic w_in_evt;
  logic w_out_evt;
  logic w_out_req;

  logic r_in_level_d;
  logic r_out_level_d;
  logic r_pend;
  logic r_in_pulse;
  logic r_out_pulse;
  logic r_stuck;

  sensor_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .STUCK_CYCLES    (STUCK_CYCLES),
    .DB_W            (DB_W),
    .ST_W            (ST_W)
  ) u_entry (
    .clk       (clk),
    .reset     (reset),
    .i_raw     (sns.in_raw),
    .o_level   (w_in_level),
    .o_stuck_c (w_in_stuck)
  );

  sensor_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .STUCK_CYCLES    (STUCK_CYCLES),
    .DB_W            (DB_W),
    .ST_W            (ST_W)
  ) u_exit (
    .clk       (clk),
    .reset     (reset),
    .i_raw     (sns.out_raw),
    .o_level   (w_out_level),
    .o_stuck_c (w_out_stuck)
  );

  assign w_in_evt  = w_in_level & ~r_in_level_d;
  assign w_out_evt = w_out_level & ~r_out_level_d;
  assign w_out_req = w_out_evt | r_pend;

  // Entry wins a collision; the exit is held in r_pend and issued on the next free cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_level_d  <= 1'b0;
      r_out_level_d <= 1'b0;
      r_pend        <= 1'b0;
      r_in_pulse    <= 1'b0;
      r_out_pulse   <= 1'b0;
      r_stuck       <= 1'b0;
    end else begin
      r_in_level_d  <= w_in_level;
      r_out_level_d <= w_out_level;
      r_in_pulse    <= w_in_evt;
      r_out_pulse   <= w_out_req & ~w_in_evt;
      r_pend        <= w_out_req & w_in_evt;
      r_stuck       <= w_in_stuck | w_out_stuck;
    end
  end

  assign sns.in_pulse     = r_in_pulse;
  assign sns.out_pulse    = r_out_pulse;
  assign sns.in_level     = w_in_level;
  assign sns.out_level    = w_out_level;
  assign sns.sensor_stuck = r_stuck;

endmodule

// File: tb/tb_queue_sensor_conditioner.sv
// Bench for queue_sensor_conditioner: directed scenarios plus random bouncy inputs vs a reference model.
module tb_queue_sensor_conditioner;

  localparam int unsigned DEB = 4;
  localparam int unsigned STK = 16;

  logic clk = 1'b0;
  logic reset;

  queue_sensor_conditioner_if sns();

  queue_sensor_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .STUCK_CYCLES    (STK),
    .DB_W            (3),
    .ST_W            (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sns   (sns)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: sample-window debounce, integer pending-exit count, unbounded high-run timers
  bit m_d1[2], m_d2[2], m_lvl[2], m_lvl_d[2];
  bit m_in_p, m_out_p, m_stuck;
  int m_run[2];
  int m_pend_n, m_pend_max;
  bit m_win_in[$];
  bit m_win_out[$];

  task automatic model_update(input bit rin, input bit rout, input bit rst);
    bit s[2];
    bit evt[2];
    bit win[$];
    bit all_diff;
    int pend_total;
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_d1[c] = 0; m_d2[c] = 0; m_lvl[c] = 0; m_lvl_d[c] = 0; m_run[c] = 0;
      end
      m_in_p = 0; m_out_p = 0; m_stuck = 0; m_pend_n = 0;
      m_win_in.delete();
      m_win_out.delete();
    end else begin
      for (int c = 0; c < 2; c++) begin
        s[c]   = m_d2[c];
        m_d2[c] = m_d1[c];
        evt[c] = m_lvl[c] && !m_lvl_d[c];
      end
      m_d1[0] = rin;
      m_d1[1] = rout;
      pend_total = m_pend_n + (evt[1] ? 1 : 0);
      m_in_p = evt[0];
      m_out_p = 0;
      if (!evt[0] && pend_total > 0) begin
        m_out_p = 1;
        pend_total--;
      end
      m_pend_n = pend_total;
      if (m_pend_n > m_pend_max) m_pend_max = m_pend_n;
      m_stuck = (m_run[0] >= int'(STK)) || (m_run[1] >= int'(STK));
      for (int c = 0; c < 2; c++) begin
        m_run[c]   = m_lvl[c] ? m_run[c] + 1 : 0;
        m_lvl_d[c] = m_lvl[c];
        if (c == 0) win = m_win_in; else win = m_win_out;
        win.push_back(s[c]);
        if (win.size() > int'(DEB)) void'(win.pop_front());
        if (win.size() == int'(DEB)) begin
          all_diff = 1;
          foreach (win[i]) if (win[i] == m_lvl[c]) all_diff = 0;
          if (all_diff) begin
            m_lvl[c] = !m_lvl[c];
            win.delete();
          end
        end
        if (c == 0) m_win_in = win; else m_win_out = win;
      end
    end
  endtask

  // Per-scenario observations, edge-indexed from the last mark()
  int cyc, first_in, first_out, first_lvl, first_olvl, first_stuck;
  int n_in, n_out, wide, both, ds_count;
  bit lvl_seen, prev_in, prev_out;

  task automatic mark();
    cyc = -1; first_in = -1; first_out = -1; first_lvl = -1; first_olvl = -1; first_stuck = -1;
    n_in = 0; n_out = 0; wide = 0; both = 0; ds_count = 0;
    lvl_seen = 0; prev_in = 0; prev_out = 0;
  endtask

  task automatic step(input bit rin, input bit rout, input bit rst);
    @(negedge clk);
    sns.in_raw  = rin;
    sns.out_raw = rout;
    reset       = rst;
    @(posedge clk);
    model_update(rin, rout, rst);
    #1;
    check("in_pulse",     sns.in_pulse,     m_in_p);
    check("out_pulse",    sns.out_pulse,    m_out_p);
    check("in_level",     sns.in_level,     m_lvl[0]);
    check("out_level",    sns.out_level,    m_lvl[1]);
    check("sensor_stuck", sns.sensor_stuck, m_stuck);
    cyc++;
    if (sns.in_pulse === 1'b1) begin
      n_in++; ds_count++;
      if (first_in < 0) first_in = cyc;
      if (prev_in) wide++;
    end
    if (sns.out_pulse === 1'b1) begin
      n_out++; ds_count--;
      if (first_out < 0) first_out = cyc;
      if (prev_out) wide++;
    end
    if (sns.in_pulse === 1'b1 && sns.out_pulse === 1'b1) both++;
    if (sns.in_level === 1'b1) begin
      lvl_seen = 1;
      if (first_lvl < 0) first_lvl = cyc;
    end
    if (sns.out_level === 1'b1 && first_olvl < 0) first_olvl = cyc;
    if (sns.sensor_stuck === 1'b1 && first_stuck < 0) first_stuck = cyc;
    prev_in  = (sns.in_pulse === 1'b1);
    prev_out = (sns.out_pulse === 1'b1);
  endtask

  int unsigned hold[2];
  bit          val[2];
  bit          g[2];

  initial begin
    sns.in_raw  = 1'b0;
    sns.out_raw = 1'b0;
    reset       = 1'b1;
    m_pend_max  = 0;
    mark();

    // 1: raw entry high through reset re-qualifies after release
    repeat (3) step(1, 0, 1);
    check("t1_rst_pulse", sns.in_pulse, 0);
    check("t1_rst_level", sns.in_level, 0);
    mark();
    repeat (12) step(1, 0, 0);
    check("t1_level_edge", first_lvl, 5);
    check("t1_pulse_edge", first_in, 6);
    check("t1_pulse_cnt", n_in, 1);

    // 2: toggling input never qualifies
    repeat (2) step(0, 0, 1);
    repeat (4) step(0, 0, 0);
    mark();
    for (int i = 0; i < 20; i++) step(bit'(i % 2 == 0), 0, 0);
    repeat (10) step(0, 0, 0);
    check("t2_pulse_cnt", n_in, 0);
    check("t2_level_seen", lvl_seen, 0);

    // 3: simultaneous clean rises, entry first
    repeat (2) step(0, 0, 1);
    repeat (4) step(0, 0, 0);
    mark();
    repeat (12) step(1, 1, 0);
    repeat (8) step(0, 0, 0);
    check("t3_in_edge", first_in, 6);
    check("t3_out_edge", first_out, 7);
    check("t3_in_cnt", n_in, 1);
    check("t3_out_cnt", n_out, 1);
    check("t3_overlap", both, 0);

    // 4: three clean entries
    repeat (2) step(0, 0, 1);
    repeat (2) step(0, 0, 0);
    mark();
    repeat (3) begin
      repeat (10) step(1, 0, 0);
      repeat (10) step(0, 0, 0);
    end
    check("t4_pulse_cnt", n_in, 3);
    check("t4_wide", wide, 0);
    check("t4_downstream", ds_count, 3);

    // 5: exit held long enough to trip the stuck flag
    repeat (2) step(0, 0, 1);
    repeat (2) step(0, 0, 0);
    mark();
    repeat (30) step(0, 1, 0);
    repeat (10) step(0, 0, 0);
    check("t5_out_cnt", n_out, 1);
    check("t5_level_edge", first_olvl, 5);
    check("t5_stuck_edge", first_stuck, 22);
    check("t5_stuck_end", sns.sensor_stuck, 0);

    // 6: reset while an exit is deferred discards it
    repeat (2) step(0, 0, 1);
    repeat (2) step(0, 0, 0);
    mark();
    repeat (7) step(1, 1, 0);
    check("t6_pend_set", dut.r_pend, 1);
    step(0, 0, 1);
    mark();
    repeat (15) step(0, 0, 0);
    check("t6_out_after_rst", n_out, 0);
    check("t6_pend_clear", dut.r_pend, 0);

    // Random bouncy inputs with occasional reset
    repeat (2) step(0, 0, 1);
    mark();
    hold[0] = 0; hold[1] = 0; val[0] = 0; val[1] = 0;
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (hold[c] == 0) begin
          val[c]  = bit'($urandom % 2);
          hold[c] = $urandom_range(1, 40);
        end
        hold[c]--;
        g[c] = val[c] ^ ($urandom_range(0, 9) == 0);
      end
      step(g[0], g[1], $urandom_range(0, 399) == 0);
    end
    check("rand_overlap", both, 0);
    check("rand_wide", wide, 0);
    check("pend_bound", (m_pend_max <= 1) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
